multicycle_control: RTL and testbench

Finite-state sequencer for the multi-cycle MIPS datapath: a single ALU, a unified instruction/data memory and the register file are reused across several cycles per instruction. The block drives every datapath mux select and write enable from its current state and the 6-bit opcode held in the instruction register. Memory accesses complete via a ready handshake, so wait-state memories are supported.

---
 rtl/multicycle_control.sv | 165 ++++++++++++++++
 tb/tb_multicycle_control.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Control sequencer for the multi-cycle MIPS datapath: walks each instruction
// through fetch/decode/execute/memory/writeback and drives every mux select and enable.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       BranchNE,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_IALUWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    assign state = state_q;

    always_comb begin
        state_d     = S_FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNE    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        illegal_op  = 1'b0;

        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                // IR load and PC+4 commit only in the cycle the read completes
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                state_d = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_LW, OP_SW:                      state_d = S_MEMADR;
                    OP_RTYPE:                          state_d = S_EXEC;
                    OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IEXEC;
                    OP_J:                              state_d = S_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                state_d  = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCSource    = 2'b01;
                PCWriteCond = 1'b1;
                BranchNE    = (opcode == OP_BNE);
            end
            S_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = (opcode == OP_ADDI) ? 2'b00 : 2'b11;
                state_d = S_IALUWB;
            end
            S_IALUWB: begin
                RegWrite = 1'b1;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset suppresses every side effect so an abandoned instruction leaves no trace
        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            illegal_op  = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through
// its state sequence and compares controls against hand-derived values.
module tb_multicycle_control;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNE(BranchNE),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .illegal_op(illegal_op), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Enables that must all be low during reset
    wire [6:0] enables = {PCWrite, PCWriteCond, IRWrite, RegWrite, MemRead, MemWrite, illegal_op};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset for two cycles, then a j instruction straight out of reset
    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b1; opcode = 6'b000010;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (state !== 4'd0 || enables !== 7'b0) begin
                $display("FAIL reset_hold cyc%0d: state=%0d en=%b, want state=0 en=0000000", i, state, enables);
                errors++;
            end
        end
        reset = 1'b0; #1;
        checks++;
        if (IRWrite !== 1'b1 || PCWrite !== 1'b1 || MemRead !== 1'b1 || ALUSrcB !== 2'b01) begin
            $display("FAIL reset_release: IRWrite=%b PCWrite=%b MemRead=%b ALUSrcB=%b, want 1 1 1 01",
                     IRWrite, PCWrite, MemRead, ALUSrcB);
            errors++;
        end
        step();
        checks++;
        if (state !== 4'd1 || ALUSrcB !== 2'b11 || enables !== 7'b0) begin
            $display("FAIL jump_decode: state=%0d ALUSrcB=%b en=%b, want 1 11 0000000", state, ALUSrcB, enables);
            errors++;
        end
        step();
        checks++;
        if (state !== 4'd11 || PCWrite !== 1'b1 || PCSource !== 2'b10 || RegWrite !== 1'b0) begin
            $display("FAIL jump_exec: state=%0d PCWrite=%b PCSource=%b RegWrite=%b, want 11 1 10 0",
                     state, PCWrite, PCSource, RegWrite);
            errors++;
        end
        step();
        checks++;
        if (state !== 4'd0) begin
            $display("FAIL jump_return: state=%0d, want 0", state);
            errors++;
        end
    endtask

    task automatic test_lw();
        logic [3:0] exp_state [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        logic       exp_wr    [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        opcode = 6'b100011; mem_ready = 1'b1; #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (state !== exp_state[i] || RegWrite !== exp_wr[i] || MemtoReg !== exp_wr[i]) begin
                $display("FAIL lw_cyc%0d: state=%0d RegWrite=%b MemtoReg=%b, want %0d %b %b",
                         i, state, RegWrite, MemtoReg, exp_state[i], exp_wr[i], exp_wr[i]);
                errors++;
            end
            step();
        end
        checks++;
        if (state !== 4'd0) begin
            $display("FAIL lw_return: state=%0d, want 0", state);
            errors++;
        end
    endtask

    // sw with a wait in FETCH and three wait cycles in MEMWR
    task automatic test_sw_wait();
        opcode = 6'b101011; mem_ready = 1'b0; #1;
        checks++;
        if (IRWrite !== 1'b0 || PCWrite !== 1'b0 || MemRead !== 1'b1 || IorD !== 1'b0) begin
            $display("FAIL fetch_wait: IRWrite=%b PCWrite=%b MemRead=%b IorD=%b, want 0 0 1 0",
                     IRWrite, PCWrite, MemRead, IorD);
            errors++;
        end
        step();
        checks++;
        if (state !== 4'd0) begin
            $display("FAIL fetch_hold: state=%0d, want 0", state);
            errors++;
        end
        mem_ready = 1'b1;
        step(); step();
        checks++;
        if (state !== 4'd2 || ALUSrcA !== 1'b1 || ALUSrcB !== 2'b10) begin
            $display("FAIL sw_memadr: state=%0d ALUSrcA=%b ALUSrcB=%b, want 2 1 10", state, ALUSrcA, ALUSrcB);
            errors++;
        end
        step();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3); #1;
            checks++;
            if (state !== 4'd5 || MemWrite !== 1'b1 || IorD !== 1'b1 || RegWrite !== 1'b0 || MemRead !== 1'b0) begin
                $display("FAIL sw_memwr_cyc%0d: state=%0d MemWrite=%b IorD=%b RegWrite=%b MemRead=%b, want 5 1 1 0 0",
                         i, state, MemWrite, IorD, RegWrite, MemRead);
                errors++;
            end
            step();
        end
        checks++;
        if (state !== 4'd0 || RegWrite !== 1'b0) begin
            $display("FAIL sw_return: state=%0d RegWrite=%b, want 0 0", state, RegWrite);
            errors++;
        end
    endtask

    task automatic test_alu_ops();
        logic [5:0] ops     [3] = '{6'b000000, 6'b001000, 6'b001101};
        logic [3:0] ex_st   [3] = '{4'd6, 4'd9, 4'd9};
        logic [1:0] ex_op   [3] = '{2'b10, 2'b00, 2'b11};
        logic [1:0] ex_srcb [3] = '{2'b00, 2'b10, 2'b10};
        logic [3:0] wb_st   [3] = '{4'd7, 4'd10, 4'd10};
        logic       wb_dst  [3] = '{1'b1, 1'b0, 1'b0};
        mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            opcode = ops[k];
            step(); step();
            checks++;
            if (state !== ex_st[k] || ALUOp !== ex_op[k] || ALUSrcA !== 1'b1 || ALUSrcB !== ex_srcb[k]) begin
                $display("FAIL alu_exec op=%b: state=%0d ALUOp=%b ALUSrcA=%b ALUSrcB=%b, want %0d %b 1 %b",
                         ops[k], state, ALUOp, ALUSrcA, ALUSrcB, ex_st[k], ex_op[k], ex_srcb[k]);
                errors++;
            end
            step();
            checks++;
            if (state !== wb_st[k] || RegWrite !== 1'b1 || RegDst !== wb_dst[k] || MemtoReg !== 1'b0) begin
                $display("FAIL alu_wb op=%b: state=%0d RegWrite=%b RegDst=%b MemtoReg=%b, want %0d 1 %b 0",
                         ops[k], state, RegWrite, RegDst, MemtoReg, wb_st[k], wb_dst[k]);
                errors++;
            end
            step();
            checks++;
            if (state !== 4'd0) begin
                $display("FAIL alu_return op=%b: state=%0d, want 0", ops[k], state);
                errors++;
            end
        end
    endtask

    task automatic test_branch();
        logic [5:0] ops [2] = '{6'b000100, 6'b000101};
        logic       ne  [2] = '{1'b0, 1'b1};
        mem_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            opcode = ops[k];
            step(); step();
            checks++;
            if (state !== 4'd8 || PCWriteCond !== 1'b1 || PCSource !== 2'b01 || BranchNE !== ne[k] ||
                ALUOp !== 2'b01 || PCWrite !== 1'b0 || RegWrite !== 1'b0) begin
                $display("FAIL branch op=%b: state=%0d PCWriteCond=%b PCSource=%b BranchNE=%b ALUOp=%b PCWrite=%b RegWrite=%b, want 8 1 01 %b 01 0 0",
                         ops[k], state, PCWriteCond, PCSource, BranchNE, ALUOp, PCWrite, RegWrite, ne[k]);
                errors++;
            end
            step();
            checks++;
            if (state !== 4'd0) begin
                $display("FAIL branch_return op=%b: state=%0d, want 0", ops[k], state);
                errors++;
            end
        end
    endtask

    task automatic test_illegal();
        opcode = 6'b111111; mem_ready = 1'b1;
        step();
        checks++;
        if (state !== 4'd1 || enables !== 7'b0000001) begin
            $display("FAIL illegal_decode: state=%0d en=%b, want 1 0000001", state, enables);
            errors++;
        end
        step();
        checks++;
        if (state !== 4'd0 || illegal_op !== 1'b0 || RegWrite !== 1'b0) begin
            $display("FAIL illegal_return: state=%0d illegal_op=%b RegWrite=%b, want 0 0 0", state, illegal_op, RegWrite);
            errors++;
        end
    endtask

    // Reset arriving while a lw waits in MEMRD
    task automatic test_reset_midinstr();
        opcode = 6'b100011; mem_ready = 1'b1;
        step(); step();
        mem_ready = 1'b0;
        step();
        checks++;
        if (state !== 4'd3 || MemRead !== 1'b1 || IorD !== 1'b1) begin
            $display("FAIL memrd_wait: state=%0d MemRead=%b IorD=%b, want 3 1 1", state, MemRead, IorD);
            errors++;
        end
        reset = 1'b1; #1;
        checks++;
        if (enables !== 7'b0) begin
            $display("FAIL reset_in_memrd: en=%b, want 0000000", enables);
            errors++;
        end
        mem_ready = 1'b1;
        step();
        reset = 1'b0; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (state !== 4'd0 || RegWrite !== 1'b0) begin
                $display("FAIL after_reset cyc%0d: state=%0d RegWrite=%b, want 0 0", i, state, RegWrite);
                errors++;
            end
            step();
        end
    endtask

    initial begin
        reset = 1'b1; opcode = 6'b0; mem_ready = 1'b0;
        test_reset();
        test_lw();
        test_sw_wait();
        test_alu_ops();
        test_branch();
        test_illegal();
        test_reset_midinstr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
